// File: rtl/crop_window_sequencer.sv
// Crop window sequencer: owns the live crop window, double-buffers host window
// writes onto frame boundaries, tracks raster position and sequences captures.
module crop_window_sequencer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CW       = 16
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  input  logic          iCFG_WR,
  input  logic [CW-1:0] iCFG_XSTART,
  input  logic [CW-1:0] iCFG_XEND,
  input  logic [CW-1:0] iCFG_YSTART,
  input  logic [CW-1:0] iCFG_YEND,
  input  logic          iSTART,
  input  logic          iCONT,
  input  logic          iABORT,
  input  logic [CW-1:0] iDARK_CNT,
  input  logic [CW-1:0] iLIGHT_CNT,
  output logic [CW-1:0] oXSTART,
  output logic [CW-1:0] oXEND,
  output logic [CW-1:0] oYSTART,
  output logic [CW-1:0] oYEND,
  output logic          oCFG_PEND,
  output logic          oCFG_ERR,
  output logic          oBUSY,
  output logic          oCAPTURING,
  output logic          oFRAME_DONE,
  output logic          oABORTED,
  output logic [CW-1:0] oDARK,
  output logic [CW-1:0] oLIGHT,
  output logic [CW-1:0] oFRAME_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CW-1:0] xs;
    logic [CW-1:0] xe;
    logic [CW-1:0] ys;
    logic [CW-1:0] ye;
  } win_t;

  localparam logic [CW-1:0] X_LAST   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_ACTIVE - 1);
  localparam win_t          FULL_WIN = '{xs: '0, xe: X_LAST, ys: '0, ye: Y_LAST};

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  win_t          win_q, win_d;
  win_t          shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic [CW-1:0] dark_q, dark_d;
  logic [CW-1:0] light_q, light_d;
  logic [CW-1:0] fcnt_q, fcnt_d;

  logic eof;
  logic cfg_ok;
  win_t cfg_req;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    eof = 1'b0;
    if (iDVAL) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
          eof = 1'b1;
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  always_comb begin
    cfg_req = '{xs: iCFG_XSTART, xe: iCFG_XEND, ys: iCFG_YSTART, ye: iCFG_YEND};
    cfg_ok  = (iCFG_XSTART <= iCFG_XEND) && (iCFG_XEND <= X_LAST) &&
              (iCFG_YSTART <= iCFG_YEND) && (iCFG_YEND <= Y_LAST);
  end

  // Apply reads the pre-write shadow, so a write landing on the boundary
  // cycle stays pending for the following boundary.
  always_comb begin
    win_d    = win_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    err_d    = err_q;
    if (pend_q && ((state_q == ST_IDLE) || eof)) begin
      win_d  = shadow_q;
      pend_d = 1'b0;
    end
    if (iCFG_WR) begin
      if (cfg_ok) begin
        shadow_d = cfg_req;
        pend_d   = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    dark_d    = dark_q;
    light_d   = light_q;
    fcnt_d    = eof ? fcnt_q + CW'(1) : fcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!iABORT && (iSTART || iCONT)) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (iABORT) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (eof) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (iABORT) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (eof) begin
          dark_d  = iDARK_CNT;
          light_d = iLIGHT_CNT;
          done_d  = 1'b1;
          if (!iCONT) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      win_q     <= FULL_WIN;
      shadow_q  <= FULL_WIN;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      dark_q    <= '0;
      light_q   <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      win_q     <= win_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      dark_q    <= dark_d;
      light_q   <= light_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign oXSTART     = win_q.xs;
  assign oXEND       = win_q.xe;
  assign oYSTART     = win_q.ys;
  assign oYEND       = win_q.ye;
  assign oCFG_PEND   = pend_q;
  assign oCFG_ERR    = err_q;
  assign oBUSY       = (state_q != ST_IDLE);
  assign oCAPTURING  = (state_q == ST_CAPTURE);
  assign oFRAME_DONE = done_q;
  assign oABORTED    = aborted_q;
  assign oDARK       = dark_q;
  assign oLIGHT      = light_q;
  assign oFRAME_CNT  = fcnt_q;

endmodule

// File: tb/tb_crop_window_sequencer.sv
// Scoreboard bench for crop_window_sequencer: a frame-level reference model
// predicts every output each cycle; a monitor pops and compares after each edge.
module tb_crop_window_sequencer;

  localparam int unsigned H     = 16;
  localparam int unsigned V     = 8;
  localparam int unsigned CW    = 16;
  localparam int          FRAME = H * V;

  localparam int MD_IDLE  = 0;
  localparam int MD_ARMED = 1;
  localparam int MD_CAPT  = 2;

  typedef struct packed {
    logic [CW-1:0] xs;
    logic [CW-1:0] xe;
    logic [CW-1:0] ys;
    logic [CW-1:0] ye;
  } win_t;

  typedef struct packed {
    win_t          win;
    logic          pend;
    logic          err;
    logic          busy;
    logic          capt;
    logic          done;
    logic          abt;
    logic [CW-1:0] dark;
    logic [CW-1:0] light;
    logic [CW-1:0] fcnt;
  } snap_t;

  logic          clk = 1'b0;
  logic          iRST;
  logic          iDVAL, iCFG_WR, iSTART, iCONT, iABORT;
  logic [CW-1:0] iCFG_XSTART, iCFG_XEND, iCFG_YSTART, iCFG_YEND;
  logic [CW-1:0] iDARK_CNT, iLIGHT_CNT;
  logic [CW-1:0] oXSTART, oXEND, oYSTART, oYEND;
  logic          oCFG_PEND, oCFG_ERR, oBUSY, oCAPTURING, oFRAME_DONE, oABORTED;
  logic [CW-1:0] oDARK, oLIGHT, oFRAME_CNT;

  always #5 clk = ~clk;

  crop_window_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW)) dut (
    .iCLK(clk), .iRST(iRST), .iDVAL(iDVAL), .iCFG_WR(iCFG_WR),
    .iCFG_XSTART(iCFG_XSTART), .iCFG_XEND(iCFG_XEND),
    .iCFG_YSTART(iCFG_YSTART), .iCFG_YEND(iCFG_YEND),
    .iSTART(iSTART), .iCONT(iCONT), .iABORT(iABORT),
    .iDARK_CNT(iDARK_CNT), .iLIGHT_CNT(iLIGHT_CNT),
    .oXSTART(oXSTART), .oXEND(oXEND), .oYSTART(oYSTART), .oYEND(oYEND),
    .oCFG_PEND(oCFG_PEND), .oCFG_ERR(oCFG_ERR), .oBUSY(oBUSY),
    .oCAPTURING(oCAPTURING), .oFRAME_DONE(oFRAME_DONE), .oABORTED(oABORTED),
    .oDARK(oDARK), .oLIGHT(oLIGHT), .oFRAME_CNT(oFRAME_CNT)
  );

  snap_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference model: raster position kept as a linear pixel index in the frame.
  win_t          m_win, m_sh;
  logic          m_pend, m_err, m_done, m_abt;
  int            m_mode, m_pix;
  logic [CW-1:0] m_dark, m_light, m_fcnt;
  logic          cont_lvl = 1'b0;

  function automatic win_t mk_win(int xs, int xe, int ys, int ye);
    win_t w;
    w.xs = CW'(xs); w.xe = CW'(xe); w.ys = CW'(ys); w.ye = CW'(ye);
    return w;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("win=%0d/%0d/%0d/%0d pend=%b err=%b busy=%b capt=%b done=%b abt=%b dark=%0d light=%0d fcnt=%0d",
                     s.win.xs, s.win.xe, s.win.ys, s.win.ye, s.pend, s.err, s.busy,
                     s.capt, s.done, s.abt, s.dark, s.light, s.fcnt);
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.win   = mk_win(int'(oXSTART), int'(oXEND), int'(oYSTART), int'(oYEND));
    s.pend  = oCFG_PEND;  s.err  = oCFG_ERR;   s.busy = oBUSY;
    s.capt  = oCAPTURING; s.done = oFRAME_DONE; s.abt = oABORTED;
    s.dark  = oDARK;      s.light = oLIGHT;    s.fcnt = oFRAME_CNT;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.win  = m_win;  s.pend = m_pend; s.err = m_err;
    s.busy = (m_mode != MD_IDLE);
    s.capt = (m_mode == MD_CAPT);
    s.done = m_done; s.abt = m_abt;
    s.dark = m_dark; s.light = m_light; s.fcnt = m_fcnt;
    return s;
  endfunction

  task automatic check_snap(input string name, input snap_t e);
    snap_t g;
    g = dut_snap();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s @%0t got {%s} exp {%s}", name, $time, fmt(g), fmt(e));
    end
  endtask

  task automatic model_reset();
    m_win  = mk_win(0, H - 1, 0, V - 1);
    m_sh   = m_win;
    m_pend = 1'b0; m_err = 1'b0; m_done = 1'b0; m_abt = 1'b0;
    m_mode = MD_IDLE; m_pix = 0;
    m_dark = '0; m_light = '0; m_fcnt = '0;
  endtask

  task automatic model_step();
    bit   eof, ok;
    win_t req;
    eof = iDVAL && (m_pix == FRAME - 1);
    req = mk_win(int'(iCFG_XSTART), int'(iCFG_XEND), int'(iCFG_YSTART), int'(iCFG_YEND));
    ok  = (req.xs <= req.xe) && (req.xe < H) && (req.ys <= req.ye) && (req.ye < V);
    m_done = 1'b0;
    m_abt  = 1'b0;
    if (m_pend && (m_mode == MD_IDLE || eof)) begin
      m_win  = m_sh;
      m_pend = 1'b0;
    end
    if (iCFG_WR) begin
      if (ok) begin
        m_sh = req; m_pend = 1'b1; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    case (m_mode)
      MD_IDLE:  if (!iABORT && (iSTART || iCONT)) m_mode = MD_ARMED;
      MD_ARMED: begin
        if (iABORT) begin m_mode = MD_IDLE; m_abt = 1'b1; end
        else if (eof) m_mode = MD_CAPT;
      end
      default: begin
        if (iABORT) begin
          m_mode = MD_IDLE; m_abt = 1'b1;
        end else if (eof) begin
          m_dark = iDARK_CNT; m_light = iLIGHT_CNT; m_done = 1'b1;
          if (!iCONT) m_mode = MD_IDLE;
        end
      end
    endcase
    if (eof) m_fcnt = m_fcnt + CW'(1);
    if (iDVAL) m_pix = (m_pix + 1) % FRAME;
  endtask

  task automatic cyc(input bit dv, input bit wr, input win_t w, input bit st, input bit ab);
    @(negedge clk);
    iRST        = 1'b1;
    iDVAL       = dv;
    iCFG_WR     = wr;
    iCFG_XSTART = w.xs; iCFG_XEND = w.xe; iCFG_YSTART = w.ys; iCFG_YEND = w.ye;
    iSTART      = st;
    iCONT       = cont_lvl;
    iABORT      = ab;
    iDARK_CNT   = CW'($urandom);
    iLIGHT_CNT  = CW'($urandom);
    model_step();
    exp_q.push_back(model_snap());
  endtask

  task automatic idle_cyc(input bit dv);
    cyc(dv, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run(input int n, input int pct);
    for (int k = 0; k < n; k++) idle_cyc($urandom_range(0, 99) < pct);
  endtask

  // Advance until the next pixel with iDVAL=1 is the last one of the frame.
  task automatic to_last();
    for (int k = 0; k < 4 * FRAME && m_pix != FRAME - 1; k++)
      idle_cyc($urandom_range(0, 99) < 85);
  endtask

  task automatic do_reset();
    @(negedge clk);
    iRST = 1'b0; iDVAL = 1'b0; iCFG_WR = 1'b0; iSTART = 1'b0; iABORT = 1'b0;
    #1;
    model_reset();
    check_snap("async_reset", model_snap());
    exp_q.push_back(model_snap());
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_snap("cycle", e);
      end
    end
  end

  initial begin : stimulus
    iRST = 1'b0; iDVAL = 1'b0; iCFG_WR = 1'b0; iSTART = 1'b0; iCONT = 1'b0; iABORT = 1'b0;
    iCFG_XSTART = '0; iCFG_XEND = '0; iCFG_YSTART = '0; iCFG_YEND = '0;
    iDARK_CNT = '0; iLIGHT_CNT = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_snap("reset_values", model_snap());

    // Window write while idle, then an invalid write and a clearing write.
    cyc(1'b1, 1'b1, mk_win(4, 10, 1, 5), 1'b0, 1'b0);
    run(4, 80);
    cyc(1'b1, 1'b1, mk_win(12, 6, 0, 3), 1'b0, 1'b0);
    run(3, 80);
    cyc(1'b0, 1'b1, mk_win(2, 13, 2, 6), 1'b0, 1'b0);
    run(3, 80);

    // Single-shot capture.
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    run(3 * FRAME, 90);

    // Continuous capture over three frames with writes mid-frame and on EOF.
    cont_lvl = 1'b1;
    idle_cyc(1'b1);
    to_last(); idle_cyc(1'b1);
    to_last(); idle_cyc(1'b1);
    run(40, 85);
    cyc(1'b1, 1'b1, mk_win(1, 9, 0, 4), 1'b0, 1'b0);
    to_last();
    cyc(1'b1, 1'b1, mk_win(5, 15, 3, 7), 1'b0, 1'b0);
    run(30, 85);
    cont_lvl = 1'b0;
    to_last(); idle_cyc(1'b1);
    run(5, 85);

    // Abort mid-capture, abort on EOF, abort together with start.
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    to_last(); idle_cyc(1'b1);
    run(30, 85);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
    run(5, 85);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    to_last(); idle_cyc(1'b1);
    to_last();
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    run(5, 85);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
    run(3, 85);

    // Stall mid-line, reset mid-frame, then a clean capture.
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    to_last(); idle_cyc(1'b1);
    run(10, 100);
    run(20, 0);
    run(5, 100);
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    run(3 * FRAME, 90);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 99) == 0) cont_lvl = ~cont_lvl;
      cyc($urandom_range(0, 99) < 85,
          $urandom_range(0, 99) < 3,
          mk_win($urandom_range(0, H + 1), $urandom_range(0, H + 1),
                 $urandom_range(0, V + 1), $urandom_range(0, V + 1)),
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 149) == 0);
    end
    cont_lvl = 1'b0;
    run(10, 85);

    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crop_window_sequencer.md
Name: crop_window_sequencer

Overview:
- Controls the pixel crop stage: holds its live window registers, double-buffers host window updates so they only change on frame boundaries, and sequences single-shot or continuous frame captures.
- Tracks raster position from the same valid-pixel stream the crop stage sees.
- At each captured frame end, latches the crop stage's dark/light pixel counters into stable result registers.
- Sits between host configuration logic and the crop stage.

Parameters:
H_ACTIVE, 640, valid pixels per line
V_ACTIVE, 480, lines per frame
CW, 16, width of coordinate, counter and frame-count fields

Ports:
iCLK  in  1  pixel clock
iRST  in  1  asynchronous active-low reset
iDVAL  in  1  pixel valid, same strobe fed to the crop stage
iCFG_WR  in  1  single-cycle window write strobe
iCFG_XSTART  in  CW  requested window X start
iCFG_XEND  in  CW  requested window X end
iCFG_YSTART  in  CW  requested window Y start
iCFG_YEND  in  CW  requested window Y end
iSTART  in  1  single-cycle request to capture one frame
iCONT  in  1  level; continuous capture while high
iABORT  in  1  single-cycle abort
iDARK_CNT  in  CW  crop stage dark counter
iLIGHT_CNT  in  CW  crop stage light counter
oXSTART/oXEND/oYSTART/oYEND  out  CW each  live window to crop stage
oCFG_PEND  out  1  shadow window waiting for a boundary
oCFG_ERR  out  1  last write rejected (sticky)
oBUSY  out  1  state is ARMED or CAPTURE
oCAPTURING  out  1  current frame is the captured frame
oFRAME_DONE  out  1  one-cycle pulse, capture complete
oABORTED  out  1  one-cycle pulse, capture aborted
oDARK  out  CW  latched dark count
oLIGHT  out  CW  latched light count
oFRAME_CNT  out  CW  completed-frame counter

Behaviour:
- Reset values:
  - All outputs 0, except window outputs = full frame: XSTART=0, XEND=H_ACTIVE-1, YSTART=0, YEND=V_ACTIVE-1.
  - Shadow window = same full-frame values.
  - Position counters X=0, Y=0; state IDLE.
- Position tracking (all states):
  - Each cycle with iDVAL=1: X increments; when X reaches H_ACTIVE-1 it wraps to 0 and Y increments.
  - At X=H_ACTIVE-1 with Y=V_ACTIVE-1, Y wraps to 0. That cycle is the last-pixel (EOF) cycle.
  - No position change when iDVAL=0.
- Frame boundary: the clock edge of the EOF cycle. At that edge oFRAME_CNT increments, wrapping mod 2^CW.
- Config write (iCFG_WR=1):
  - Valid iff XSTART<=XEND<H_ACTIVE and YSTART<=YEND<V_ACTIVE.
  - Valid write: loads shadow, sets oCFG_PEND, clears oCFG_ERR.
  - Invalid write: shadow unchanged, sets oCFG_ERR.
  - A later write overwrites a pending shadow.
- Apply rules:
  - In IDLE, a pending shadow is copied to the window outputs on the next edge, and oCFG_PEND clears.
  - Otherwise the copy happens only at a frame boundary.
  - Write on the same cycle as EOF: the boundary applies the old shadow; the new value stays pending for the next boundary (or the next IDLE cycle).
- States:
  - IDLE: on iSTART or iCONT=1 go to ARMED.
  - ARMED: wait for a frame boundary, then go to CAPTURE. The window is applied at that boundary, so the captured frame always uses one consistent window.
  - CAPTURE: oCAPTURING=1. On the EOF edge:
    - latch oDARK<=iDARK_CNT and oLIGHT<=iLIGHT_CNT;
    - pulse oFRAME_DONE next cycle;
    - if iCONT=1, stay in CAPTURE for the next frame; else go to IDLE.
  - The latched counts cover pixels 0..N-2 of the window (the final pixel's update is excluded); this is accepted.
- oBUSY=1 in ARMED or CAPTURE.
- Abort:
  - iABORT in ARMED or CAPTURE: go to IDLE next edge, pulse oABORTED, no oFRAME_DONE, oDARK/oLIGHT unchanged.
  - iABORT in IDLE is ignored.
  - iABORT together with EOF in CAPTURE: abort wins, no latch.
  - iABORT together with iSTART: abort wins.
- iSTART while ARMED or CAPTURE is ignored.
- Dropping iCONT mid-capture finishes the current frame, then goes to IDLE.
- Asynchronous reset mid-frame returns everything to reset values immediately; the position counters restart at (0,0). The crop stage shares the same reset, so the two stay aligned.

Test Plan:
- Reset, then write window 200/400/60/200 while IDLE -> window outputs updated within 2 cycles; oCFG_PEND pulses high then low; oCFG_ERR=0.
- Write XSTART=500, XEND=300 -> oCFG_ERR=1; window unchanged; a later valid write clears oCFG_ERR.
- iSTART, then drive a full 640x480 frame with iDARK_CNT=100, iLIGHT_CNT=50 at EOF -> oCAPTURING=1 for exactly the frame after arming; oFRAME_DONE one pulse; oDARK=100, oLIGHT=50; state IDLE; oFRAME_CNT advanced per frame.
- iCONT high across 3 frames with a window write during frame 2 -> new window appears only at the frame-2 EOF edge; 3 oFRAME_DONE pulses; write on the EOF cycle lands one frame later.
- iABORT mid-CAPTURE, and iABORT coincident with EOF -> oABORTED pulse; no oFRAME_DONE; oDARK/oLIGHT retain previous values.
- Stall iDVAL low 20 cycles mid-line, then assert reset mid-frame -> position holds during the stall; reset returns all outputs to reset values and the next frame captures correctly.
